stream_demux_1xn: RTL and testbench

Registered, parametrised 1-to-N stream demultiplexer with valid/ready flow control on every port. Each beat is routed to the output channel named by its select field, or copied to all channels in broadcast mode, and held in a one-entry register per channel until that channel's consumer accepts it. It is the clocked, multi-bit, multi-channel successor to the team's 1x2 combinational demux. It sits between a single producer and up to N independent consumers.

---
 rtl/stream_demux_1xn_if.sv | 26 ++
 rtl/stream_demux_1xn.sv | 82 ++++++++
 tb/tb_stream_demux_1xn.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_demux_1xn_if.sv
// Stream bundle for the 1-to-N demux: one producer-facing port and N consumer-facing channels.
// The demux itself connects through the slave modport; the driving side uses master.
interface stream_demux_1xn_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SEL_W-1:0]   in_sel;
  logic               in_bcast;
  logic [N-1:0]       out_valid;
  logic [N-1:0]       out_ready;
  logic [N*WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/stream_demux_1xn.sv
// Registered 1-to-N stream demux: unicast by select or broadcast to all channels,
// one holding slot per channel, and a saturating counter of beats with an out-of-range select.
module stream_demux_1xn #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  stream_demux_1xn_if.slave bus,
  output logic [7:0]       drop_cnt
);

  logic [N-1:0]       vld_reg;
  logic [WIDTH-1:0]   dat_reg [N];
  logic [N-1:0]       free;
  logic [N-1:0]       sel_hit;
  logic [N-1:0]       load;
  logic [N*WIDTH-1:0] out_data_flat;
  logic               sel_ok;
  logic               in_ready;
  logic               accept;
  logic               drop;
  logic [7:0]         drop_cnt_reg;

  // One-hot decode of the select keeps every channel lookup in range, even when N is not a power of 2.
  for (genvar gi = 0; gi < N; gi++) begin : g_decode
    assign sel_hit[gi] = (bus.in_sel == SEL_W'(gi));
    assign free[gi]    = !vld_reg[gi] || bus.out_ready[gi];
  end

  assign sel_ok = |sel_hit;

  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      if (bus.in_bcast) begin
        in_ready = &free;
      end else if (sel_ok) begin
        in_ready = |(sel_hit & free);
      end else begin
        in_ready = 1'b1;
      end
    end
  end

  assign accept = bus.in_valid && in_ready;
  assign drop   = accept && !bus.in_bcast && !sel_ok;
  assign load   = {N{accept}} & (bus.in_bcast ? {N{1'b1}} : sel_hit);

  // A load wins over a drain on the same edge, so a busy channel still moves one beat per cycle.
  for (genvar gi = 0; gi < N; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_reg[gi] <= 1'b0;
        dat_reg[gi] <= '0;
      end else if (load[gi]) begin
        vld_reg[gi] <= 1'b1;
        dat_reg[gi] <= bus.in_data;
      end else if (bus.out_ready[gi]) begin
        vld_reg[gi] <= 1'b0;
        dat_reg[gi] <= '0;
      end
    end

    assign out_data_flat[gi*WIDTH +: WIDTH] = dat_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_reg <= '0;
    end else if (drop && (drop_cnt_reg != 8'hFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_reg;
  assign bus.out_data  = out_data_flat;
  assign drop_cnt      = drop_cnt_reg;

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Bench for stream_demux_1xn: directed scenarios on a 4-channel and a 3-channel instance,
// plus a per-channel ordered-queue scoreboard watching the 4-channel instance.
module tb_stream_demux_1xn;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] drop4;
  logic [7:0] drop3;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  logic [7:0] sbq [4][$];

  always #5 clk = ~clk;

  stream_demux_1xn_if #(.WIDTH(8), .N(4)) b4 ();
  stream_demux_1xn_if #(.WIDTH(8), .N(3)) b3 ();

  stream_demux_1xn #(.WIDTH(8), .N(4)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .bus      (b4),
    .drop_cnt (drop4)
  );

  stream_demux_1xn #(.WIDTH(8), .N(3)) dut3 (
    .clk      (clk),
    .rst      (rst),
    .bus      (b3),
    .drop_cnt (drop3)
  );

  // Scoreboard: inputs are stable from just after a rising edge, so the falling edge sees
  // exactly the handshakes the next rising edge will act on.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        for (int k = 0; k < 4; k++) sbq[k].delete();
      end else begin
        for (int k = 0; k < 4; k++) begin
          n_cmp++;
          if ((sbq[k].size() != 0) !== b4.out_valid[k]) begin
            n_err++;
            $display("FAIL sb_occupancy ch%0d: out_valid=%b expected held=%0d", k, b4.out_valid[k], sbq[k].size());
          end
          if (b4.out_valid[k] && sbq[k].size() != 0) begin
            n_cmp++;
            if (b4.out_data[k*8 +: 8] !== sbq[k][0]) begin
              n_err++;
              $display("FAIL sb_data ch%0d: got %h expected %h", k, b4.out_data[k*8 +: 8], sbq[k][0]);
            end
          end else if (!b4.out_valid[k]) begin
            n_cmp++;
            if (b4.out_data[k*8 +: 8] !== 8'h00) begin
              n_err++;
              $display("FAIL sb_empty_zero ch%0d: got %h expected 00", k, b4.out_data[k*8 +: 8]);
            end
          end
        end
        for (int k = 0; k < 4; k++) begin
          if (b4.out_valid[k] && b4.out_ready[k] && sbq[k].size() != 0) void'(sbq[k].pop_front());
        end
        if (b4.in_valid && b4.in_ready) begin
          for (int k = 0; k < 4; k++) begin
            if (b4.in_bcast || (b4.in_sel == 2'(k))) sbq[k].push_back(b4.in_data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b4.in_valid = 1'b0; b4.in_data = '0; b4.in_sel = '0; b4.in_bcast = 1'b0; b4.out_ready = 4'hF;
    b3.in_valid = 1'b0; b3.in_data = '0; b3.in_sel = '0; b3.in_bcast = 1'b0; b3.out_ready = 3'h7;
    tick(); tick();
    rst = 1'b0;
    mon_en = 1'b1;
    tick();
    // Preload every channel so reset has something to discard.
    b4.out_ready = 4'h0; b4.in_bcast = 1'b1; b4.in_data = 8'h33; b4.in_valid = 1'b1;
    tick();
    b4.in_valid = 1'b0; b4.in_bcast = 1'b0;
    n_cmp++;
    if (b4.out_valid !== 4'hF) begin n_err++; $display("FAIL reset_preload: got %b expected 1111", b4.out_valid); end
    rst = 1'b1;
    b4.in_valid = 1'b1; b4.in_sel = 2'd0; b4.in_data = 8'hC3; b4.out_ready = 4'hF;
    #1;
    n_cmp++;
    if (b4.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b expected 0", b4.in_ready); end
    tick(); tick();
    n_cmp++;
    if (b4.out_valid !== 4'h0) begin n_err++; $display("FAIL reset_valid: got %b expected 0000", b4.out_valid); end
    n_cmp++;
    if (b4.out_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h expected 00000000", b4.out_data); end
    n_cmp++;
    if (drop4 !== 8'd0 || drop3 !== 8'd0) begin n_err++; $display("FAIL reset_drop: got %0d/%0d expected 0/0", drop4, drop3); end
    n_cmp++;
    if (b4.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready_hold: got %b expected 0", b4.in_ready); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (b4.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b expected 1", b4.in_ready); end
    tick();
    b4.in_valid = 1'b0;
    n_cmp++;
    if (b4.out_valid !== 4'b0001 || b4.out_data !== 32'h000000C3) begin
      n_err++; $display("FAIL reset_first_accept: got %b/%h expected 0001/000000c3", b4.out_valid, b4.out_data);
    end
    tick();
    $display("test_reset done");
  endtask

  task automatic test_unicast();
    b4.out_ready = 4'hF;
    b4.in_data = 8'hA5; b4.in_sel = 2'd2; b4.in_bcast = 1'b0; b4.in_valid = 1'b1;
    #1;
    n_cmp++;
    if (b4.in_ready !== 1'b1) begin n_err++; $display("FAIL unicast_ready: got %b expected 1", b4.in_ready); end
    tick();
    b4.in_valid = 1'b0;
    n_cmp++;
    if (b4.out_valid !== 4'b0100) begin n_err++; $display("FAIL unicast_valid: got %b expected 0100", b4.out_valid); end
    n_cmp++;
    if (b4.out_data !== 32'h00A50000) begin n_err++; $display("FAIL unicast_data: got %h expected 00a50000", b4.out_data); end
    tick();
    n_cmp++;
    if (b4.out_valid !== 4'b0000) begin n_err++; $display("FAIL unicast_drain: got %b expected 0000", b4.out_valid); end
    $display("test_unicast done");
  endtask

  task automatic test_backpressure();
    b4.out_ready = 4'b1101;
    b4.in_data = 8'h11; b4.in_sel = 2'd1; b4.in_valid = 1'b1;
    tick();
    b4.in_data = 8'h22;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (b4.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall_ready cycle%0d: got %b expected 0", i, b4.in_ready); end
      tick();
      n_cmp++;
      if (b4.out_valid !== 4'b0010 || b4.out_data[15:8] !== 8'h11) begin
        n_err++; $display("FAIL bp_hold cycle%0d: got %b/%h expected 0010/11", i, b4.out_valid, b4.out_data[15:8]);
      end
    end
    b4.out_ready = 4'hF;
    #1;
    n_cmp++;
    if (b4.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b expected 1", b4.in_ready); end
    tick();
    b4.in_valid = 1'b0;
    n_cmp++;
    if (b4.out_valid !== 4'b0010 || b4.out_data !== 32'h00002200) begin
      n_err++; $display("FAIL bp_replace: got %b/%h expected 0010/00002200", b4.out_valid, b4.out_data);
    end
    tick();
    n_cmp++;
    if (b4.out_valid !== 4'b0000) begin n_err++; $display("FAIL bp_drain: got %b expected 0000", b4.out_valid); end
    $display("test_backpressure done");
  endtask

  task automatic test_broadcast();
    b4.out_ready = 4'b0111;
    b4.in_data = 8'h77; b4.in_sel = 2'd3; b4.in_bcast = 1'b0; b4.in_valid = 1'b1;
    tick();
    b4.in_data = 8'h5A; b4.in_bcast = 1'b1; b4.in_sel = 2'd0;
    #1;
    n_cmp++;
    if (b4.in_ready !== 1'b0) begin n_err++; $display("FAIL bcast_gate_ready: got %b expected 0", b4.in_ready); end
    tick();
    n_cmp++;
    if (b4.out_valid !== 4'b1000 || b4.out_data !== 32'h77000000) begin
      n_err++; $display("FAIL bcast_no_partial: got %b/%h expected 1000/77000000", b4.out_valid, b4.out_data);
    end
    b4.out_ready = 4'hF;
    #1;
    n_cmp++;
    if (b4.in_ready !== 1'b1) begin n_err++; $display("FAIL bcast_release_ready: got %b expected 1", b4.in_ready); end
    tick();
    b4.in_valid = 1'b0; b4.in_bcast = 1'b0;
    n_cmp++;
    if (b4.out_valid !== 4'b1111 || b4.out_data !== 32'h5A5A5A5A) begin
      n_err++; $display("FAIL bcast_all: got %b/%h expected 1111/5a5a5a5a", b4.out_valid, b4.out_data);
    end
    tick();
    $display("test_broadcast done");
  endtask

  task automatic test_back_to_back();
    b4.out_ready = 4'b1110;
    b4.in_data = 8'h01; b4.in_sel = 2'd0; b4.in_bcast = 1'b0; b4.in_valid = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      b4.in_sel = 2'(1 + i % 3);
      b4.in_data = 8'(8'h40 + i);
      #1;
      n_cmp++;
      if (b4.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready beat%0d: got %b expected 1", i, b4.in_ready); end
      tick();
    end
    b4.in_valid = 1'b0;
    n_cmp++;
    if (b4.out_valid !== 4'b1001 || b4.out_data !== 32'h48000001) begin
      n_err++; $display("FAIL b2b_final: got %b/%h expected 1001/48000001", b4.out_valid, b4.out_data);
    end
    b4.out_ready = 4'hF;
    tick();
    n_cmp++;
    if (b4.out_valid !== 4'b0000) begin n_err++; $display("FAIL b2b_drain: got %b expected 0000", b4.out_valid); end
    $display("test_back_to_back done");
  endtask

  task automatic test_invalid_sel();
    int exp_cnt;
    b3.out_ready = 3'b000;
    b3.in_data = 8'hEE; b3.in_sel = 2'd3; b3.in_bcast = 1'b0; b3.in_valid = 1'b1;
    for (int i = 0; i < 260; i++) begin
      #1;
      n_cmp++;
      if (b3.in_ready !== 1'b1) begin n_err++; $display("FAIL inv_ready beat%0d: got %b expected 1", i, b3.in_ready); end
      tick();
      exp_cnt = (i + 1 > 255) ? 255 : i + 1;
      n_cmp++;
      if (drop3 !== 8'(exp_cnt) || b3.out_valid !== 3'b000) begin
        n_err++; $display("FAIL inv_drop beat%0d: got cnt=%0d valid=%b expected cnt=%0d valid=000", i, drop3, b3.out_valid, exp_cnt);
      end
    end
    b3.in_valid = 1'b0;
    b3.out_ready = 3'b111;
    tick();
    n_cmp++;
    if (drop3 !== 8'd255 || b3.out_data !== 24'h0) begin
      n_err++; $display("FAIL inv_final: got cnt=%0d data=%h expected 255/000000", drop3, b3.out_data);
    end
    $display("test_invalid_sel done");
  endtask

  task automatic test_random();
    bit acc = 1'b0;
    b4.in_valid = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (!b4.in_valid || acc) begin
        b4.in_valid = ($urandom_range(0, 3) != 0);
        b4.in_data = 8'($urandom);
        b4.in_sel = 2'($urandom_range(0, 3));
        b4.in_bcast = ($urandom_range(0, 7) == 0);
      end
      for (int k = 0; k < 4; k++) b4.out_ready[k] = ($urandom_range(0, 3) != 0);
      #1;
      acc = b4.in_valid && b4.in_ready;
      tick();
    end
    b4.in_valid = 1'b0;
    b4.in_bcast = 1'b0;
    b4.out_ready = 4'hF;
    tick(); tick();
    n_cmp++;
    if (b4.out_valid !== 4'b0000) begin n_err++; $display("FAIL rand_drain: got %b expected 0000", b4.out_valid); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (sbq[k].size() != 0) begin n_err++; $display("FAIL rand_leftover ch%0d: got %0d pending expected 0", k, sbq[k].size()); end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_backpressure();
    test_broadcast();
    test_back_to_back();
    test_invalid_sel();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
